// File: rtl/aes_round_ctrl.sv
// AES round-sequencing controller for AES-128/192/256 (NK = 4/6/8), encrypt and decrypt.
// Optional abort input enabled by defining AES_CTRL_ABORT_EN.
module aes_round_ctrl #(
    parameter int NK = 4,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          decrypt,
`ifdef AES_CTRL_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] round_idx,
    output logic          sel_text,
    output logic          sel_key,
    output logic          ld_text,
    output logic          ld_key,
    output logic          ld_expand,
    output logic          rk_we,
    output logic          ld_ark,
    output logic          ld_sub,
    output logic          ld_shift,
    output logic          ld_mix,
    output logic          inv
);

    localparam logic [RW-1:0] NR  = RW'(NK + 6);
    localparam logic [RW-1:0] ONE = RW'(1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_KEXP   = 4'd2,
        S_ARK0   = 4'd3,
        S_EKEY   = 4'd4,
        S_ESUB   = 4'd5,
        S_ESHIFT = 4'd6,
        S_EMIX   = 4'd7,
        S_EARK   = 4'd8,
        S_DSHIFT = 4'd9,
        S_DSUB   = 4'd10,
        S_DARK   = 4'd11,
        S_DMIX   = 4'd12,
        S_DONE   = 4'd13
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    mode_d  = decrypt;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (mode_q) begin
                    state_d = S_KEXP;
                    cnt_d   = ONE;
                end else begin
                    state_d = S_ARK0;
                end
            end
            // Decrypt pre-expands the whole schedule so rounds can run in reverse order.
            S_KEXP: begin
                if (cnt_q == NR) begin
                    state_d = S_ARK0;
                    cnt_d   = NR;
                end else begin
                    cnt_d   = cnt_q + ONE;
                end
            end
            S_ARK0: begin
                if (mode_q) begin
                    state_d = S_DSHIFT;
                    cnt_d   = NR - ONE;
                end else begin
                    state_d = S_EKEY;
                    cnt_d   = ONE;
                end
            end
            S_EKEY:   state_d = S_ESUB;
            S_ESUB:   state_d = S_ESHIFT;
            S_ESHIFT: state_d = (cnt_q == NR) ? S_EARK : S_EMIX;
            S_EMIX:   state_d = S_EARK;
            S_EARK: begin
                if (cnt_q == NR) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_EKEY;
                    cnt_d   = cnt_q + ONE;
                end
            end
            S_DSHIFT: state_d = S_DSUB;
            S_DSUB:   state_d = S_DARK;
            S_DARK:   state_d = (cnt_q == '0) ? S_DONE : S_DMIX;
            S_DMIX: begin
                state_d = S_DSHIFT;
                cnt_d   = cnt_q - ONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                mode_d  = 1'b0;
            end
        endcase
`ifdef AES_CTRL_ABORT_EN
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
`endif
    end

    // Moore output decode; round_idx is only meaningful while a key-store access is strobed.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        round_idx = '0;
        sel_text  = 1'b0;
        sel_key   = 1'b0;
        ld_text   = 1'b0;
        ld_key    = 1'b0;
        ld_expand = 1'b0;
        rk_we     = 1'b0;
        ld_ark    = 1'b0;
        ld_sub    = 1'b0;
        ld_shift  = 1'b0;
        ld_mix    = 1'b0;
        inv       = mode_q;
        case (state_q)
            S_IDLE: begin
            end
            S_LOAD: begin
                busy    = 1'b1;
                ld_text = 1'b1;
                ld_key  = 1'b1;
            end
            S_KEXP: begin
                busy      = 1'b1;
                ld_expand = 1'b1;
                rk_we     = 1'b1;
                round_idx = cnt_q;
            end
            S_ARK0: begin
                busy      = 1'b1;
                ld_ark    = 1'b1;
                round_idx = mode_q ? NR : '0;
            end
            S_EKEY: begin
                busy      = 1'b1;
                ld_expand = 1'b1;
                sel_key   = 1'b1;
                ld_key    = 1'b1;
            end
            S_ESUB, S_DSUB: begin
                busy   = 1'b1;
                ld_sub = 1'b1;
            end
            S_ESHIFT, S_DSHIFT: begin
                busy     = 1'b1;
                ld_shift = 1'b1;
            end
            S_EMIX, S_DMIX: begin
                busy   = 1'b1;
                ld_mix = 1'b1;
            end
            S_EARK, S_DARK: begin
                busy      = 1'b1;
                ld_ark    = 1'b1;
                sel_text  = 1'b1;
                ld_text   = 1'b1;
                round_idx = cnt_q;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                inv = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: NK=4 and NK=8 instances, per-cycle strobe traces.
module tb_aes_round_ctrl;

    localparam logic [12:0] F_BUSY  = 13'h1000;
    localparam logic [12:0] F_DONE  = 13'h0800;
    localparam logic [12:0] F_SELT  = 13'h0400;
    localparam logic [12:0] F_SELK  = 13'h0200;
    localparam logic [12:0] F_LDT   = 13'h0100;
    localparam logic [12:0] F_LDK   = 13'h0080;
    localparam logic [12:0] F_LDE   = 13'h0040;
    localparam logic [12:0] F_RKWE  = 13'h0020;
    localparam logic [12:0] F_ARK   = 13'h0010;
    localparam logic [12:0] F_SUB   = 13'h0008;
    localparam logic [12:0] F_SHIFT = 13'h0004;
    localparam logic [12:0] F_MIX   = 13'h0002;
    localparam logic [12:0] F_INV   = 13'h0001;

    typedef struct packed {
        logic [12:0] flags;
        logic [3:0]  idx;
        logic [16:0] care;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start4, dec4, start8, dec8;
`ifdef AES_CTRL_ABORT_EN
    logic abort4, abort8;
`endif
    logic       busy4, done4, selt4, selk4, ldt4, ldk4, lde4, rkwe4, ark4, sub4, shift4, mix4, inv4;
    logic       busy8, done8, selt8, selk8, ldt8, ldk8, lde8, rkwe8, ark8, sub8, shift8, mix8, inv8;
    logic [3:0] idx4, idx8;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cntExp, cntMix, cntArk, cntRkwe, doneAt, maxIdx;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NK(4), .RW(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .decrypt(dec4),
`ifdef AES_CTRL_ABORT_EN
        .abort(abort4),
`endif
        .busy(busy4), .done(done4), .round_idx(idx4), .sel_text(selt4), .sel_key(selk4),
        .ld_text(ldt4), .ld_key(ldk4), .ld_expand(lde4), .rk_we(rkwe4), .ld_ark(ark4),
        .ld_sub(sub4), .ld_shift(shift4), .ld_mix(mix4), .inv(inv4)
    );

    aes_round_ctrl #(.NK(8), .RW(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .decrypt(dec8),
`ifdef AES_CTRL_ABORT_EN
        .abort(abort8),
`endif
        .busy(busy8), .done(done8), .round_idx(idx8), .sel_text(selt8), .sel_key(selk8),
        .ld_text(ldt8), .ld_key(ldk8), .ld_expand(lde8), .rk_we(rkwe8), .ld_ark(ark8),
        .ld_sub(sub8), .ld_shift(shift8), .ld_mix(mix8), .inv(inv8)
    );

    function automatic logic [16:0] obsOf(input int sel);
        if (sel == 8)
            return {busy8, done8, selt8, selk8, ldt8, ldk8, lde8, rkwe8, ark8, sub8, shift8, mix8, inv8, idx8};
        return {busy4, done4, selt4, selk4, ldt4, ldk4, lde4, rkwe4, ark4, sub4, shift4, mix4, inv4, idx4};
    endfunction

    // Mux selects only matter while their register loads; round_idx only while a key access is strobed.
    function automatic exp_t mk(input logic [12:0] f, input int idx, input bit idxv);
        exp_t e;
        e.flags = f;
        e.idx   = 4'(idx);
        e.care  = '1;
        if (!idxv) e.care[3:0] = 4'h0;
        if ((f & F_LDT) == 13'h0) e.care[14] = 1'b0;
        if ((f & F_LDK) == 13'h0) e.care[13] = 1'b0;
        return e;
    endfunction

    task automatic genOp(input int nr, input bit dec);
        logic [12:0] base;
        base = F_BUSY | (dec ? F_INV : 13'h0);
        expQ.push_back(mk(base | F_LDT | F_LDK, 0, 0));
        if (!dec) begin
            expQ.push_back(mk(base | F_ARK, 0, 1));
            for (int r = 1; r <= nr; r++) begin
                expQ.push_back(mk(base | F_LDE | F_SELK | F_LDK, 0, 0));
                expQ.push_back(mk(base | F_SUB, 0, 0));
                expQ.push_back(mk(base | F_SHIFT, 0, 0));
                if (r < nr) expQ.push_back(mk(base | F_MIX, 0, 0));
                expQ.push_back(mk(base | F_ARK | F_SELT | F_LDT, r, 1));
            end
        end else begin
            for (int r = 1; r <= nr; r++) expQ.push_back(mk(base | F_LDE | F_RKWE, r, 1));
            expQ.push_back(mk(base | F_ARK, nr, 1));
            for (int r = nr - 1; r >= 0; r--) begin
                expQ.push_back(mk(base | F_SHIFT, 0, 0));
                expQ.push_back(mk(base | F_SUB, 0, 0));
                expQ.push_back(mk(base | F_ARK | F_SELT | F_LDT, r, 1));
                if (r > 0) expQ.push_back(mk(base | F_MIX, 0, 0));
            end
        end
        expQ.push_back(mk(base | F_DONE, 0, 0));
    endtask

    task automatic setStart(input int sel, input logic v, input logic d);
        if (sel == 8) begin
            start8 = v;
            dec8   = d;
        end else begin
            start4 = v;
            dec4   = d;
        end
    endtask

    // Called at a falling edge with the DUT idle; the following rising edge accepts.
    task automatic startOp(input int sel, input bit dec);
        setStart(sel, 1'b1, dec);
        genOp((sel == 8) ? 14 : 10, dec);
        @(negedge clk);
    endtask

    task automatic drainQ(input int sel, input int startAt, input bit startAtDone,
                          input int toggleAt, input int stopAt);
        int         i;
        exp_t       e;
        logic [16:0] o;
        logic        d;
        i = 0;
        cntExp = 0; cntMix = 0; cntArk = 0; cntRkwe = 0; doneAt = -1; maxIdx = 0;
        d = (sel == 8) ? dec8 : dec4;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsOf(sel);
            checks++;
            if ((o & e.care) !== ({e.flags, e.idx} & e.care)) begin
                errors++;
                $display("[TB] FAIL trace nk%0d cycle %0d: got %05h want %05h (care %05h)",
                         (sel == 8) ? 8 : 4, i, o, {e.flags, e.idx}, e.care);
            end
            if (o[10] === 1'b1) cntExp++;
            if (o[5] === 1'b1) cntMix++;
            if (o[8] === 1'b1) cntArk++;
            if (o[9] === 1'b1) cntRkwe++;
            if (o[15] === 1'b1 && doneAt < 0) doneAt = i;
            if (o[8] === 1'b1 && int'(o[3:0]) > maxIdx) maxIdx = int'(o[3:0]);
            if (i == toggleAt) d = ~d;
            setStart(sel, (i == startAt) || (startAtDone && ((e.flags & F_DONE) != 13'h0)), d);
            if (i == stopAt) break;
            i++;
            @(negedge clk);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic checkIdle(input int sel, input string name);
        logic [16:0] o;
        o = obsOf(sel);
        checks++;
        if (o[16:15] !== 2'b00) begin
            errors++;
            $display("[TB] FAIL %s: busy/done got %b want 00", name, o[16:15]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start4 = 1'b0; dec4 = 1'b0; start8 = 1'b0; dec8 = 1'b0;
`ifdef AES_CTRL_ABORT_EN
        abort4 = 1'b0; abort8 = 1'b0;
`endif
        #1;
        for (int s = 4; s <= 8; s += 4) begin
            checks++;
            if (obsOf(s) !== 17'h0) begin
                errors++;
                $display("[TB] FAIL reset nk%0d: got %05h want 00000", s, obsOf(s));
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_encrypt128;
        startOp(4, 1'b0);
        drainQ(4, -1, 1'b0, -1, -1);
        checkInt("enc128 latency", doneAt, 51);
        checkInt("enc128 ld_expand count", cntExp, 10);
        checkInt("enc128 ld_mix count", cntMix, 9);
        checkInt("enc128 ld_ark count", cntArk, 11);
        checkIdle(4, "enc128 idle after done");
    endtask

    task automatic test_decrypt128;
        startOp(4, 1'b1);
        drainQ(4, -1, 1'b0, -1, -1);
        checkInt("dec128 latency", doneAt, 51);
        checkInt("dec128 rk_we count", cntRkwe, 10);
        checkInt("dec128 ld_mix count", cntMix, 9);
        checkInt("dec128 ld_ark count", cntArk, 11);
        checkIdle(4, "dec128 idle after done");
    endtask

    task automatic test_nk8;
        for (int m = 0; m < 2; m++) begin
            startOp(8, m[0]);
            drainQ(8, -1, 1'b0, -1, -1);
            checkInt(m == 0 ? "enc256 latency" : "dec256 latency", doneAt, 71);
            checkInt(m == 0 ? "enc256 peak idx" : "dec256 peak idx", maxIdx, 14);
            checkInt(m == 0 ? "enc256 ld_mix count" : "dec256 ld_mix count", cntMix, 13);
            checkIdle(8, "nk8 idle after done");
        end
    endtask

    task automatic test_back_to_back;
        startOp(4, 1'b0);
        drainQ(4, 20, 1'b1, 10, -1);
        checkIdle(4, "b2b idle gap");
        setStart(4, 1'b1, 1'b1);
        genOp(10, 1'b1);
        @(negedge clk);
        drainQ(4, -1, 1'b0, -1, -1);
        checkInt("b2b second latency", doneAt, 51);
        checkIdle(4, "b2b idle after second");
    endtask

    task automatic test_async_reset;
        startOp(4, 1'b0);
        drainQ(4, -1, 1'b0, -1, 22);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obsOf(4) !== 17'h0) begin
            errors++;
            $display("[TB] FAIL async reset: got %05h want 00000", obsOf(4));
        end
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        startOp(4, 1'b0);
        drainQ(4, -1, 1'b0, -1, -1);
        checkInt("post-reset latency", doneAt, 51);
    endtask

`ifdef AES_CTRL_ABORT_EN
    task automatic test_abort;
        bit sawDone;
        startOp(4, 1'b0);
        drainQ(4, -1, 1'b0, -1, 13);
        abort4 = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        checks++;
        if (obsOf(4) !== 17'h0) begin
            errors++;
            $display("[TB] FAIL abort to idle: got %05h want 00000", obsOf(4));
        end
        abort4 = 1'b0;
        start4 = 1'b0;
        expQ.delete();
        sawDone = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done4 !== 1'b0) sawDone = 1'b1;
        end
        checkInt("abort no done", int'(sawDone), 0);
        startOp(4, 1'b0);
        drainQ(4, -1, 1'b0, -1, -1);
        checkInt("post-abort latency", doneAt, 51);
    endtask
`endif

    initial begin
        test_reset();
        test_encrypt128();
        test_decrypt128();
        test_nk8();
        test_back_to_back();
        test_async_reset();
`ifdef AES_CTRL_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Parametrised AES round-sequencing controller for the AES datapath (text/key registers, key expander, SubBytes/ShiftRows/MixColumns/AddRoundKey stages).
- Supports AES-128/192/256 through the NK parameter, and both encrypt and decrypt through a per-operation mode bit.
- Keeps its round counter internally, so the datapath supplies no comparator flags.
- Uses a start/busy/done handshake and an async reset.

Parameters:
NK, 4, key length in 32-bit words; legal values 4, 6, 8. Localparam NR = NK+6 (10/12/14 rounds).
RW, 4, width of round_idx; must satisfy 2^RW > NR.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request one block operation; sampled only in IDLE
decrypt  in  1  mode, sampled with an accepted start; 0=encrypt, 1=decrypt
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; result valid in the text register
round_idx  out  RW  current round-key index for the key store
sel_text  out  1  text-register mux: 0=input block, 1=round result
sel_key  out  1  key-register mux: 0=cipher key, 1=expander output
ld_text  out  1  load text register
ld_key  out  1  load key register
ld_expand  out  1  advance key expander by one 128-bit round key
rk_we  out  1  write expander output to key store at round_idx
ld_ark  out  1  load AddRoundKey stage
ld_sub  out  1  load (Inv)SubBytes stage
ld_shift  out  1  load (Inv)ShiftRows stage
ld_mix  out  1  load (Inv)MixColumns stage
inv  out  1  select inverse transforms; equals the latched mode

Behaviour:
- Reset (async, immediate, also mid-operation):
  - state=IDLE, round counter=0, mode=0.
  - All outputs 0, including round_idx.
- Outputs are Moore-decoded from state, counter and mode. The cycle after leaving a state, that state's strobes are deasserted.
- States:
  - IDLE: start=1 → LOAD; latch mode←decrypt; counter←0.
  - LOAD: sel_text=0, ld_text=1, sel_key=0, ld_key=1. Encrypt → ARK0. Decrypt → KEXP with counter←1.
  - KEXP (decrypt only): ld_expand=1, rk_we=1, round_idx=counter. counter=NR → ARK0 with counter←NR; otherwise counter+1 and stay in KEXP. Lasts exactly NR cycles.
  - ARK0: ld_ark=1; round_idx=0 (encrypt) or NR (decrypt).
    - Encrypt → EKEY with counter←1.
    - Decrypt → DSHIFT with counter←NR-1.
  - Encrypt round r = counter:
    - EKEY: ld_expand=1, sel_key=1, ld_key=1.
    - then ESUB → ESHIFT → EMIX → EARK.
    - EMIX is skipped when r=NR (ESHIFT → EARK).
    - EARK: ld_ark=1, sel_text=1, ld_text=1, round_idx=r.
    - EARK with r=NR → DONE; otherwise counter+1 → EKEY.
  - Decrypt round r = counter, inv=1:
    - DSHIFT → DSUB → DARK → DMIX.
    - DARK: round_idx=r, ld_ark=1, sel_text=1, ld_text=1.
    - DMIX is skipped when r=0 (DARK → DONE).
    - DMIX → DSHIFT with counter-1.
  - DONE: done=1, busy=1 → IDLE.
- Latency: from the edge that accepts start to the edge that enters DONE is 5·NR+1 cycles in both modes (51/61/71 for NK=4/6/8).
- Boundaries:
  - start while busy (including the DONE cycle) is ignored; no queuing.
  - decrypt changes after acceptance have no effect.
  - Counter never exceeds NR and never underflows below 0.
  - Illegal or unreachable state → IDLE on the next edge with all outputs 0.
  - start held high continuously gives back-to-back operations with one IDLE cycle between done and the next LOAD.

Optional Feature:
- Macro AES_CTRL_ABORT_EN.
- Defined: adds an input port abort (1 bit). abort=1 in any busy state forces IDLE on the next edge: counter←0, strobes 0, no done pulse. abort outranks start in the same cycle. abort in IDLE has no effect.
- Undefined: no abort port; an operation runs to completion or until rst.

Test Plan:
1. NK=4, encrypt, start pulse → 10 ld_expand pulses, 9 ld_mix pulses, 11 ld_ark pulses, round_idx 0..10, done exactly 51 cycles after acceptance, busy low the following cycle.
2. NK=4, decrypt → KEXP rk_we with round_idx 1..10 over 10 cycles, then ARK0 at idx 10, DARK idx 9..0, 9 ld_mix pulses, inv=1 throughout, done at 51 cycles.
3. NK=8, both modes → done at 71 cycles, round_idx peaks at 14, final round issues no ld_mix.
4. start re-asserted at cycle 20 of an operation, and in the DONE cycle → ignored; next LOAD only after the IDLE cycle; decrypt toggled mid-operation leaves inv unchanged.
5. rst asserted asynchronously mid-EKEY in round 5 → all outputs 0 before the next clock edge; after release, start runs a clean 51-cycle encrypt.
6. With AES_CTRL_ABORT_EN: abort and start both high during round 3 → IDLE next cycle, no done; a later start completes normally. Without the macro, the build has no abort port.
